home_inventory_evt_detect_fifo: RTL

// - N-channel parametrised event detector with hysteresis (arm/trip/re-arm) and an event log FIFO.
// - Sits between the sample source (stub snapshot or ADC capture) and the wishbone register file.
// - Per channel: saturating counters, LAST_DELTA and LAST_TS. Global: LAST_TS.
// - Each sample with >=1 event pushes one {hit_mask, ts} entry for firmware to pop.

---
 rtl/home_inventory_evt_detect_fifo_pkg.sv | 21 ++
 rtl/home_inventory_evt_detect_fifo_if.sv | 13 +
 rtl/home_inventory_evt_detect_fifo_evt_fifo.sv | 85 ++++++++
 rtl/home_inventory_evt_detect_fifo.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/home_inventory_evt_detect_fifo_pkg.sv
// Shared defaults, channel state encoding and log-entry layout for the event detector.
// Entry layout is {hit_mask, ts}, mask in the upper N_CH bits.
package home_inventory_pkg;

    localparam int unsigned DEF_N_CH       = 8;
    localparam int unsigned DEF_SAMPLE_W   = 32;
    localparam int unsigned DEF_TS_W       = 32;
    localparam int unsigned DEF_CNT_W      = 32;
    localparam int unsigned DEF_FIFO_DEPTH = 16;
    localparam int unsigned DROP_W         = 16;

    typedef enum logic {
        CH_ARMED   = 1'b0,
        CH_TRIPPED = 1'b1
    } ch_state_e;

    function automatic int unsigned entry_w(input int unsigned n_ch, input int unsigned ts_w);
        return n_ch + ts_w;
    endfunction

endpackage

// File: rtl/home_inventory_evt_detect_fifo_if.sv
// Event-log read port: FWFT head entry plus the consumer's pop strobe.
interface home_inventory_evt_detect_fifo_if #(
    parameter int unsigned N_CH = home_inventory_pkg::DEF_N_CH,
    parameter int unsigned TS_W = home_inventory_pkg::DEF_TS_W
);
    logic            rd_valid;
    logic            rd_ready;
    logic [N_CH-1:0] rd_mask;
    logic [TS_W-1:0] rd_ts;

    modport master (output rd_valid, output rd_mask, output rd_ts, input rd_ready);
    modport slave  (input rd_valid, input rd_mask, input rd_ts, output rd_ready);
endinterface

// File: rtl/home_inventory_evt_detect_fifo_evt_fifo.sv
// Synchronous first-word-fall-through log FIFO with level, overflow sticky and drop counter.
// A push at full is accepted when a pop happens in the same cycle.
module home_inventory_evt_fifo
    import home_inventory_pkg::*;
#(
    parameter int unsigned WIDTH = 40,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [WIDTH-1:0]  din_i,
    input  logic              pop_i,
    input  logic              ovf_clr_i,
    output logic [WIDTH-1:0]  dout_o,
    output logic              valid_o,
    output logic [AW:0]       level_o,
    output logic              ovf_o,
    output logic [DROP_W-1:0] drop_cnt_o
);

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       level_q, level_d;
    logic              ovf_q, ovf_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              empty, full, pop_ok, push_ok, drop;

    assign empty   = (level_q == '0);
    assign full    = (level_q == FULL_LVL);
    assign pop_ok  = pop_i & ~empty;
    assign push_ok = push_i & (~full | pop_ok);
    assign drop    = push_i & full & ~pop_ok;

    always_comb begin
        level_d = level_q;
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: ;
        endcase

        // Clear first, then account this cycle's drop so a coincident drop leaves count=1.
        ovf_d  = ovf_q;
        drop_d = drop_q;
        if (ovf_clr_i) begin
            ovf_d  = 1'b0;
            drop_d = '0;
        end
        if (drop) begin
            ovf_d = 1'b1;
            if (drop_d != '1) drop_d = drop_d + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o     = empty ? '0 : mem_q[rd_ptr_q];
    assign valid_o    = ~empty;
    assign level_o    = level_q;
    assign ovf_o      = ovf_q;
    assign drop_cnt_o = drop_q;

endmodule

// File: rtl/home_inventory_evt_detect_fifo.sv
// N-channel hysteresis event detector with per-channel history and an event log FIFO.
// Optional trip hold-off: define HOME_INV_EVT_HOLDOFF_EN to add the holdoff port.
module home_inventory_evt_detect_fifo
    import home_inventory_pkg::*;
#(
    parameter int unsigned N_CH       = DEF_N_CH,
    parameter int unsigned SAMPLE_W   = DEF_SAMPLE_W,
    parameter int unsigned TS_W       = DEF_TS_W,
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sample_valid,
    input  logic [TS_W-1:0]              ts_now,
    input  logic [N_CH-1:0]              evt_en,
    input  logic [N_CH*SAMPLE_W-1:0]     thresh_hi,
    input  logic [N_CH*SAMPLE_W-1:0]     thresh_lo,
    input  logic [N_CH*SAMPLE_W-1:0]     sample_flat,
    input  logic [N_CH-1:0]              cnt_clr,
    output logic [N_CH*CNT_W-1:0]        evt_count,
    output logic [N_CH*TS_W-1:0]         last_delta,
    output logic [N_CH*TS_W-1:0]         last_ts_ch,
    output logic [TS_W-1:0]              last_ts,
    home_inventory_evt_detect_fifo_if.master rd,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                         ovf_sticky,
    input  logic                         ovf_clr,
`ifdef HOME_INV_EVT_HOLDOFF_EN
    input  logic [TS_W-1:0]              holdoff,
`endif
    output logic [DROP_W-1:0]            drop_cnt
);

    localparam int unsigned ENT_W = entry_w(N_CH, TS_W);

    logic [N_CH-1:0]  fire;
    logic [TS_W-1:0]  last_ts_q;
    logic [ENT_W-1:0] head;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [SAMPLE_W-1:0] smp, hi, lo, lo_eff;
        ch_state_e           st_q, st_d;
        logic                hist_q, hist_d, pend_q, pend_d, en_prev_q;
        logic                rise, hist_eff, trip, suppress, fire_c;
        logic [CNT_W-1:0]    cnt_q, cnt_d;
        logic [TS_W-1:0]     ts_q, ts_d, dl_q, dl_d, since;

        assign smp      = sample_flat[i*SAMPLE_W +: SAMPLE_W];
        assign hi       = thresh_hi[i*SAMPLE_W +: SAMPLE_W];
        assign lo       = thresh_lo[i*SAMPLE_W +: SAMPLE_W];
        assign lo_eff   = (lo > hi) ? hi : lo;
        assign rise     = evt_en[i] & ~en_prev_q;
        // An enable edge seen now or since the last sample invalidates history for this sample.
        assign hist_eff = hist_q & ~pend_q & ~rise;
        assign since    = ts_now - ts_q;

`ifdef HOME_INV_EVT_HOLDOFF_EN
        assign suppress = (holdoff != '0) & hist_eff & (since < holdoff);
`else
        assign suppress = 1'b0;
`endif

        always_comb begin
            st_d   = st_q;
            cnt_d  = cnt_q;
            ts_d   = ts_q;
            dl_d   = dl_q;
            hist_d = hist_q;
            pend_d = pend_q;
            trip   = 1'b0;

            if (!evt_en[i]) begin
                st_d = CH_ARMED;
            end else if (sample_valid) begin
                case (st_q)
                    CH_ARMED: begin
                        if (smp >= hi) begin
                            st_d = CH_TRIPPED;
                            trip = 1'b1;
                        end
                    end
                    CH_TRIPPED: if (smp < lo_eff) st_d = CH_ARMED;
                    default:    st_d = CH_ARMED;
                endcase
            end

            fire_c = trip & ~cnt_clr[i] & ~suppress;

            if (sample_valid) begin
                pend_d = 1'b0;
                if (pend_q | rise) hist_d = 1'b0;
            end else if (rise) begin
                pend_d = 1'b1;
            end

            if (fire_c) begin
                if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                ts_d   = ts_now;
                dl_d   = hist_eff ? since : '0;
                hist_d = 1'b1;
            end

            if (cnt_clr[i]) begin
                cnt_d  = '0;
                hist_d = 1'b0;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                st_q      <= CH_ARMED;
                cnt_q     <= '0;
                ts_q      <= '0;
                dl_q      <= '0;
                hist_q    <= 1'b0;
                pend_q    <= 1'b0;
                en_prev_q <= 1'b0;
            end else begin
                st_q      <= st_d;
                cnt_q     <= cnt_d;
                ts_q      <= ts_d;
                dl_q      <= dl_d;
                hist_q    <= hist_d;
                pend_q    <= pend_d;
                en_prev_q <= evt_en[i];
            end
        end

        assign fire[i]                        = fire_c;
        assign evt_count[i*CNT_W +: CNT_W]    = cnt_q;
        assign last_delta[i*TS_W +: TS_W]     = dl_q;
        assign last_ts_ch[i*TS_W +: TS_W]     = ts_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_ts_q <= '0;
        end else if (|fire) begin
            last_ts_q <= ts_now;
        end
    end

    assign last_ts = last_ts_q;

    home_inventory_evt_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (|fire),
        .din_i      ({fire, ts_now}),
        .pop_i      (rd.rd_ready),
        .ovf_clr_i  (ovf_clr),
        .dout_o     (head),
        .valid_o    (rd.rd_valid),
        .level_o    (fifo_level),
        .ovf_o      (ovf_sticky),
        .drop_cnt_o (drop_cnt)
    );

    assign rd.rd_mask = head[TS_W +: N_CH];
    assign rd.rd_ts   = head[TS_W-1:0];

endmodule
